muldiv_ctrl: RTL and testbench

- Multi-cycle sequencer for the RV32M multiply/divide operations that the single-cycle Alu does not execute.
- Accepts one operation from the execute stage, runs a 32-step iterative shift-add multiply or restoring divide, and returns one result with a one-cycle done pulse.
- Drives busy, which the pipeline uses as a stall. Sits beside Alu in the execute stage; the execute result mux selects between the two.

---
 rtl/riscv_pkg.sv | 40 ++++
 rtl/muldiv_datapath.sv | 151 +++++++++++++++
 rtl/muldiv_ctrl.sv | 113 +++++++++++
 tb/tb_muldiv_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32M definitions for the execute stage.
// Holds the M-extension funct3 codes, the multiply/divide sequencer state
// encoding, and helpers that tell which operands of an M op are signed.
package riscv_pkg;

    localparam logic [2:0] FN3_MUL    = 3'd0;
    localparam logic [2:0] FN3_MULH   = 3'd1;
    localparam logic [2:0] FN3_MULHSU = 3'd2;
    localparam logic [2:0] FN3_MULHU  = 3'd3;
    localparam logic [2:0] FN3_DIV    = 3'd4;
    localparam logic [2:0] FN3_DIVU   = 3'd5;
    localparam logic [2:0] FN3_REM    = 3'd6;
    localparam logic [2:0] FN3_REMU   = 3'd7;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MULT = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_OUT  = 2'd3;

    // rs1 is treated as signed for MULH, MULHSU, DIV and REM.
    function automatic logic sign_a_op(input logic [2:0] fn3);
        logic r;
        case (fn3)
            FN3_MULH, FN3_MULHSU, FN3_DIV, FN3_REM: r = 1'b1;
            default:                                r = 1'b0;
        endcase
        return r;
    endfunction

    // rs2 is treated as signed for MULH, DIV and REM.
    function automatic logic sign_b_op(input logic [2:0] fn3);
        logic r;
        case (fn3)
            FN3_MULH, FN3_DIV, FN3_REM: r = 1'b1;
            default:                    r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Working registers and arithmetic for the iterative multiply/divide unit.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   state         sequencer state (selects multiply or divide step)
//   start         load operands this cycle (IDLE acceptance)
//   mode          funct3 of the incoming op (used at acceptance / fast path)
//   AiA, AiB      incoming rs1 / rs2 operands
//   fast          the incoming op is resolved without iterating
//   result        value to latch into Mout: fast-path result while IDLE,
//                 otherwise the final result assuming this is the last step
module muldiv_datapath
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      state,
    input  logic            start,
    input  logic [2:0]      mode,
    input  logic [XLEN-1:0] AiA,
    input  logic [XLEN-1:0] AiB,
    output logic            fast,
    output logic [XLEN-1:0] result
);

    logic [2:0]        mode_r;
    logic              signa_r;
    logic              signb_r;
    logic [XLEN-1:0]   opa_r;      // multiplicand magnitude
    logic [XLEN-1:0]   opb_r;      // multiplier (shifts right) / divisor
    logic [2*XLEN-1:0] acc_r;      // product, or {remainder, quotient}

    logic [XLEN-1:0]   abs_a_s;
    logic [XLEN-1:0]   abs_b_s;
    logic [XLEN-1:0]   fast_res_s;
    logic [XLEN:0]     sum_s;
    logic [XLEN:0]     rem_sh_s;
    logic [XLEN+1:0]   diff_s;
    logic [2*XLEN-1:0] acc_nxt_s;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quot_s;
    logic [XLEN-1:0]   rem_s;
    logic [XLEN-1:0]   step_res_s;
    logic              b_zero_s;
    logic              ovf_s;

    // Operand magnitudes taken at acceptance.
    always_comb begin
        if (sign_a_op(mode) && AiA[XLEN-1]) begin
            abs_a_s = -AiA;
        end else begin
            abs_a_s = AiA;
        end
        if (sign_b_op(mode) && AiB[XLEN-1]) begin
            abs_b_s = -AiB;
        end else begin
            abs_b_s = AiB;
        end
    end

    // Divide-by-zero and signed-overflow cases skip the iteration entirely.
    always_comb begin
        b_zero_s = (AiB == {XLEN{1'b0}});
        ovf_s    = ((mode == FN3_DIV) || (mode == FN3_REM))
                   && (AiA == {1'b1, {(XLEN-1){1'b0}}})
                   && (AiB == {XLEN{1'b1}});
        fast     = mode[2] && (b_zero_s || ovf_s);
        // mode[1] separates REM/REMU from DIV/DIVU.
        if (b_zero_s) begin
            fast_res_s = mode[1] ? AiA : {XLEN{1'b1}};
        end else begin
            fast_res_s = mode[1] ? {XLEN{1'b0}} : AiA;
        end
    end

    // One multiply or divide iteration.
    always_comb begin
        sum_s    = {1'b0, acc_r[2*XLEN-1:XLEN]}
                   + (opb_r[0] ? {1'b0, opa_r} : {(XLEN+1){1'b0}});
        // Remainder is kept one bit wider so the shifted value cannot overflow.
        rem_sh_s = {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-1]};
        diff_s   = {1'b0, rem_sh_s} - {2'b00, opb_r};
        case (state)
            ST_MULT: acc_nxt_s = {sum_s, acc_r[XLEN-1:1]};
            ST_DIV: begin
                if (diff_s[XLEN+1]) begin
                    acc_nxt_s = {rem_sh_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
                end else begin
                    acc_nxt_s = {diff_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
                end
            end
            default: acc_nxt_s = acc_r;
        endcase
    end

    // Sign fix-up and result selection from the post-step accumulator.
    always_comb begin
        if (signa_r ^ signb_r) begin
            prod_s = -acc_nxt_s;
            quot_s = -acc_nxt_s[XLEN-1:0];
        end else begin
            prod_s = acc_nxt_s;
            quot_s = acc_nxt_s[XLEN-1:0];
        end
        if (signa_r) begin
            rem_s = -acc_nxt_s[2*XLEN-1:XLEN];
        end else begin
            rem_s = acc_nxt_s[2*XLEN-1:XLEN];
        end
        case (mode_r)
            FN3_MUL:                          step_res_s = prod_s[XLEN-1:0];
            FN3_MULH, FN3_MULHSU, FN3_MULHU:  step_res_s = prod_s[2*XLEN-1:XLEN];
            FN3_DIV, FN3_DIVU:                step_res_s = quot_s;
            default:                          step_res_s = rem_s;
        endcase
        if (state == ST_IDLE) begin
            result = fast_res_s;
        end else begin
            result = step_res_s;
        end
    end

    // Working registers: load on acceptance, step while iterating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_r  <= 3'd0;
            signa_r <= 1'b0;
            signb_r <= 1'b0;
            opa_r   <= {XLEN{1'b0}};
            opb_r   <= {XLEN{1'b0}};
            acc_r   <= {(2*XLEN){1'b0}};
        end else if (start) begin
            mode_r  <= mode;
            signa_r <= sign_a_op(mode) && AiA[XLEN-1];
            signb_r <= sign_b_op(mode) && AiB[XLEN-1];
            opa_r   <= abs_a_s;
            opb_r   <= abs_b_s;
            // Divide keeps the dividend in the quotient half and shifts it out.
            acc_r   <= mode[2] ? {{XLEN{1'b0}}, abs_a_s} : {(2*XLEN){1'b0}};
        end else if (state == ST_MULT) begin
            acc_r   <= acc_nxt_s;
            opb_r   <= opb_r >> 1;
        end else if (state == ST_DIV) begin
            acc_r   <= acc_nxt_s;
        end else begin
            acc_r   <= acc_r;
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle sequencer for RV32M multiply/divide in the execute stage.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   valid      start request, sampled only in IDLE
//   mode       funct3 (MUL..REMU)
//   AiA, AiB   rs1 / rs2 operands
//   flush      abort the operation in flight
//   busy       high whenever not IDLE (pipeline stall)
//   done       one-cycle pulse, Mout valid during it
//   Mout       result, held until the next done
module muldiv_ctrl
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid,
    input  logic [2:0]      mode,
    input  logic [XLEN-1:0] AiA,
    input  logic [XLEN-1:0] AiB,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] Mout
);

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic             start_s;
    logic             fast_s;
    logic [XLEN-1:0]  result_s;
    logic             busy_r;
    logic             done_r;
    logic [XLEN-1:0]  mout_r;

    assign busy = busy_r;
    assign done = done_r;
    assign Mout = mout_r;

    muldiv_datapath #(.XLEN(XLEN)) u_datapath (
        .clk    (clk),
        .rst    (rst),
        .state  (state_r),
        .start  (start_s),
        .mode   (mode),
        .AiA    (AiA),
        .AiB    (AiB),
        .fast   (fast_s),
        .result (result_s)
    );

    // Next-state logic; flush both aborts iteration and blocks acceptance.
    always_comb begin
        start_s     = 1'b0;
        state_nxt_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (valid && !flush) begin
                    start_s = 1'b1;
                    if (fast_s) begin
                        state_nxt_s = ST_OUT;
                    end else begin
                        state_nxt_s = mode[2] ? ST_DIV : ST_MULT;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_MULT, ST_DIV: begin
                if (flush) begin
                    state_nxt_s = ST_IDLE;
                end else if (cnt_r == CNT_W'(XLEN-1)) begin
                    state_nxt_s = ST_OUT;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, iteration counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            mout_r  <= {XLEN{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
            done_r  <= (state_nxt_s == ST_OUT);
            if (start_s) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if ((state_r == ST_MULT) || (state_r == ST_DIV)) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
            // Result is captured on the edge that enters OUT so it lines up with done.
            if (state_nxt_s == ST_OUT) begin
                mout_r <= result_s;
            end else begin
                mout_r <= mout_r;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  mode = 3'd0;
    logic [31:0] AiA = 32'd0;
    logic [31:0] AiB = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] Mout;

    int errs = 0;
    int checks = 0;
    logic [31:0] last_exp = 32'd0;

    always #5 clk = ~clk;

    muldiv_ctrl u_dut (
        .clk   (clk),
        .rst   (rst),
        .valid (valid),
        .mode  (mode),
        .AiA   (AiA),
        .AiB   (AiB),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .Mout  (Mout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: RV32M semantics via 64-bit integer arithmetic.
    function automatic logic [31:0] model(input logic [2:0] m, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        r  = 32'd0;
        case (m)
            3'd0: begin p = ua * ub; r = p[31:0];  end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: begin
                if (b == 32'd0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
                else begin p = sa / sb; r = p[31:0]; end
            end
            3'd5: begin
                if (b == 32'd0) r = 32'hFFFF_FFFF;
                else begin p = ua / ub; r = p[31:0]; end
            end
            3'd6: begin
                if (b == 32'd0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
                else begin p = sa % sb; r = p[31:0]; end
            end
            default: begin
                if (b == 32'd0) r = a;
                else begin p = ua % ub; r = p[31:0]; end
            end
        endcase
        return r;
    endfunction

    function automatic bit is_fast(input logic [2:0] m, input logic [31:0] a, input logic [31:0] b);
        return m[2] && ((b == 32'd0) || (!m[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // Called at a negedge; the op is accepted at the following posedge (cycle 0).
    task automatic run_op(input logic [2:0] m, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input bit hold, input string tag);
        int lat;
        int exp_lat;
        lat = 0;
        exp_lat = is_fast(m, a, b) ? 1 : 33;
        mode = m; AiA = a; AiB = b; valid = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (n == 1) begin
                check({tag, "_busy1"}, 32'(busy), 32'd1);
                if (!hold) valid = 1'b0;
            end
            if (done) begin
                lat = n;
                break;
            end
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_mout"}, Mout, exp);
        @(negedge clk);
        check({tag, "_pulse"}, 32'(done), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
        check({tag, "_hold"}, Mout, exp);
        valid = 1'b0;
        last_exp = exp;
    endtask

    logic [2:0]  t_m [12];
    logic [31:0] t_a [12];
    logic [31:0] t_b [12];
    logic [31:0] t_e [12];

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        t_m = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd7, 3'd4, 3'd6};
        t_a = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        t_b = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2,
                32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        t_e = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};

        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_mout", Mout, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_op(t_m[i], t_a[i], t_b[i], t_e[i], 1'b0, $sformatf("dir%0d", i));
        end

        // flush a DIV at cycle 10, then a MUL accepted in cycle 11
        mode = 3'd4; AiA = 32'd1000; AiB = 32'd3; valid = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (n == 1) valid = 1'b0;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_done", 32'(done), 32'd0);
        check("flush_mout", Mout, last_exp);
        run_op(3'd0, 32'd3, 32'd4, 32'd12, 1'b0, "after_flush");

        // flush in IDLE blocks acceptance
        mode = 3'd0; AiA = 32'd5; AiB = 32'd5; valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        valid = 1'b0; flush = 1'b0;
        check("flush_idle_busy", 32'(busy), 32'd0);

        // asynchronous reset mid-multiply
        mode = 3'd0; AiA = 32'd7; AiB = 32'd9; valid = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            if (n == 1) valid = 1'b0;
        end
        rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_mout", Mout, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(3'd0, 32'd2, 32'd2, 32'd4, 1'b0, "after_rst");

        // valid held through OUT must not start a new op
        run_op(3'd5, 32'd100, 32'd7, 32'd14, 1'b1, "hold_valid");

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  m;
            logic [31:0] a, b;
            m = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            run_op(m, a, b, model(m, a, b), 1'b0, $sformatf("rnd%0d_m%0d", i, m));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
